// File: rtl/bus_control_ws.sv
`default_nettype none
// ============================================================================
//  Module   : bus_control_ws
//  Purpose  : 68000 bus controller for Pixy-class boards. It decodes the
//             24-bit CPU address into PROM, SRAM and signal I/O regions, with
//             a boot-time PROM overlay of the lower region. A per-region
//             wait-state FSM generates DTACK, a bus watchdog raises DTERROR,
//             and single-step mode holds DTACK until a step pulse arrives.
//  Ports    : MCLK_IN          clock, state updates on the falling edge
//             RUN_IN           synchronous active-low reset
//             AS_IN/WR_IN      address strobe (active-high) / write cycle
//             UDS_IN/LDS_IN    upper (even) / lower (odd) byte strobes
//             ADDR_IN[23:0]    byte address
//             DATA[15:0]       data bus, [7:0] driven during I/O reads
//             STEPEN_IN/STEP_IN single-step enable / step pulse
//             INPUT_SIGNAL_IN  external input signals (INSIG register)
//             OUTPUT_SIGNAL    output signal register (OUTSIG)
//             PROMCS0/1, SRAMCS0/1, OE   registered memory selects
//             DTACK/DTERROR    data acknowledge / bus error
//             BOOTSTRAPPED     PROM overlay released
//  Revision : 1.0  initial release
// ============================================================================
module bus_control_ws #(
  parameter int PROM_WS      = 2,
  parameter int SRAM_WS      = 0,
  parameter int IO_WS        = 1,
  parameter int TIMEOUT      = 64,
  parameter int BOOT_OVERLAY = 1,
  parameter int OUT_W        = 4,
  parameter int IN_W         = 4
) (
  input  logic             MCLK_IN,
  input  logic             RUN_IN,
  input  logic             AS_IN,
  input  logic             WR_IN,
  input  logic             UDS_IN,
  input  logic             LDS_IN,
  input  logic [23:0]      ADDR_IN,
  inout  wire  [15:0]      DATA,
  input  logic             STEPEN_IN,
  input  logic             STEP_IN,
  input  logic [IN_W-1:0]  INPUT_SIGNAL_IN,
  output logic [OUT_W-1:0] OUTPUT_SIGNAL,
  output logic             PROMCS0,
  output logic             PROMCS1,
  output logic             SRAMCS0,
  output logic             SRAMCS1,
  output logic             OE,
  output logic             DTACK,
  output logic             DTERROR,
  output logic             BOOTSTRAPPED
);

  // FSM encoding
  localparam logic [2:0] C_IDLE = 3'd0;
  localparam logic [2:0] C_WAIT = 3'd1;
  localparam logic [2:0] C_STEP = 3'd2;
  localparam logic [2:0] C_ACK  = 3'd3;
  localparam logic [2:0] C_ERR  = 3'd4;

  // Region encoding
  localparam logic [1:0] C_RG_PROM = 2'd0;
  localparam logic [1:0] C_RG_SRAM = 2'd1;
  localparam logic [1:0] C_RG_IO   = 2'd2;

  localparam logic [3:0] C_PROM_WS = 4'(PROM_WS);
  localparam logic [3:0] C_SRAM_WS = 4'(SRAM_WS);
  localparam logic [3:0] C_IO_WS   = 4'(IO_WS);
  localparam logic [8:0] C_TIMEOUT = 9'(TIMEOUT);
  localparam logic       C_OVERLAY = (BOOT_OVERLAY != 0);

  // --------------------------------------------------------------------------
  // Registers and wires
  // --------------------------------------------------------------------------
  logic [2:0] r_state;
  logic [2:0] w_state_nxt;

  logic [1:0] r_region;
  logic       r_uds;
  logic       r_lds;
  logic       r_wr;
  logic       r_insig;
  logic       r_lower_wr;
  logic [3:0] r_ws_cnt;
  logic [7:0] r_wd_cnt;
  logic       r_step_d;

  logic       w_dtreq;
  logic       w_dec_valid;
  logic [1:0] w_dec_region;
  logic [3:0] w_dec_ws;
  logic       w_dec_insig;
  logic       w_wd_hit;
  logic       w_step_rise;
  logic       w_take;
  logic       w_ack_entry;

  logic [1:0] w_region_nxt;
  logic       w_uds_nxt;
  logic       w_lds_nxt;
  logic       w_wr_nxt;
  logic       w_busy_nxt;
  logic       w_promcs0_nxt;
  logic       w_promcs1_nxt;
  logic       w_sramcs0_nxt;
  logic       w_sramcs1_nxt;
  logic       w_oe_nxt;
  logic       w_dtack_nxt;
  logic       w_dterror_nxt;

  logic       w_io_drive;
  logic [7:0] w_rd_byte;
  logic       w_unused_data;

  assign w_dtreq     = AS_IN & (UDS_IN | LDS_IN);
  assign w_take      = (r_state == C_IDLE) && w_dtreq;
  assign w_step_rise = STEP_IN & ~r_step_d;
  // Counting this edge would bring the watchdog to its limit.
  assign w_wd_hit    = ({1'b0, r_wd_cnt} + 9'd1) >= C_TIMEOUT;
  assign w_ack_entry = (r_state != C_ACK) && (w_state_nxt == C_ACK);

  // --------------------------------------------------------------------------
  // Address decode of the live bus request
  // --------------------------------------------------------------------------
  always_comb begin
    w_dec_valid  = 1'b0;
    w_dec_region = C_RG_PROM;
    w_dec_ws     = C_PROM_WS;
    w_dec_insig  = 1'b0;
    case (ADDR_IN[23:20])
      4'hF: begin
        w_dec_valid = 1'b1;
      end
      4'h0: begin
        // Boot overlay: reads hit PROM until the first lower-region write.
        w_dec_valid = 1'b1;
        if (WR_IN || BOOTSTRAPPED || !C_OVERLAY) begin
          w_dec_region = C_RG_SRAM;
          w_dec_ws     = C_SRAM_WS;
        end
      end
      4'h1: begin
        w_dec_region = C_RG_IO;
        w_dec_ws     = C_IO_WS;
        if (LDS_IN) begin
          if (ADDR_IN[19:0] == 20'h00001) begin
            w_dec_valid = 1'b1;
          end else if (ADDR_IN[19:0] == 20'h00003 && !WR_IN) begin
            w_dec_valid = 1'b1;
            w_dec_insig = 1'b1;
          end
        end
      end
      default: begin
        w_dec_valid = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(negedge MCLK_IN) begin
    if (!RUN_IN) begin
      r_state <= C_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      C_IDLE: begin
        if (w_dtreq) begin
          w_state_nxt = w_dec_valid ? C_WAIT : C_ERR;
        end
      end
      C_WAIT: begin
        if (!AS_IN) begin
          w_state_nxt = C_IDLE;
        end else if (w_wd_hit) begin
          w_state_nxt = C_ERR;
        end else if (r_ws_cnt == 4'd0) begin
          w_state_nxt = STEPEN_IN ? C_STEP : C_ACK;
        end
      end
      C_STEP: begin
        if (!AS_IN) begin
          w_state_nxt = C_IDLE;
        end else if (w_step_rise) begin
          w_state_nxt = C_ACK;
        end
      end
      C_ACK: begin
        if (!AS_IN) begin
          w_state_nxt = C_IDLE;
        end else if (w_wd_hit) begin
          w_state_nxt = C_ERR;
        end
      end
      C_ERR: begin
        if (!AS_IN) begin
          w_state_nxt = C_IDLE;
        end
      end
      default: begin
        w_state_nxt = C_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output logic. Outputs are registered, so they are computed from the
  // next state and the cycle attributes that will be latched on this edge.
  // --------------------------------------------------------------------------
  always_comb begin
    w_region_nxt = r_region;
    w_uds_nxt    = r_uds;
    w_lds_nxt    = r_lds;
    w_wr_nxt     = r_wr;
    if (w_take) begin
      w_region_nxt = w_dec_region;
      w_uds_nxt    = UDS_IN;
      w_lds_nxt    = LDS_IN;
      w_wr_nxt     = WR_IN;
    end
    w_busy_nxt    = (w_state_nxt == C_WAIT) || (w_state_nxt == C_STEP) ||
                    (w_state_nxt == C_ACK);
    w_promcs0_nxt = w_busy_nxt && (w_region_nxt == C_RG_PROM) && w_uds_nxt;
    w_promcs1_nxt = w_busy_nxt && (w_region_nxt == C_RG_PROM) && w_lds_nxt;
    w_sramcs0_nxt = w_busy_nxt && (w_region_nxt == C_RG_SRAM) && w_uds_nxt;
    w_sramcs1_nxt = w_busy_nxt && (w_region_nxt == C_RG_SRAM) && w_lds_nxt;
    w_oe_nxt      = w_busy_nxt && !w_wr_nxt;
    w_dtack_nxt   = (w_state_nxt == C_ACK);
    w_dterror_nxt = (w_state_nxt == C_ERR);
  end

  // --------------------------------------------------------------------------
  // Datapath: cycle latches, counters, signal registers, registered outputs
  // --------------------------------------------------------------------------
  always_ff @(negedge MCLK_IN) begin
    if (!RUN_IN) begin
      r_region      <= C_RG_PROM;
      r_uds         <= 1'b0;
      r_lds         <= 1'b0;
      r_wr          <= 1'b0;
      r_insig       <= 1'b0;
      r_lower_wr    <= 1'b0;
      r_ws_cnt      <= 4'd0;
      r_wd_cnt      <= 8'd0;
      r_step_d      <= 1'b0;
      OUTPUT_SIGNAL <= '0;
      BOOTSTRAPPED  <= 1'b0;
      PROMCS0       <= 1'b0;
      PROMCS1       <= 1'b0;
      SRAMCS0       <= 1'b0;
      SRAMCS1       <= 1'b0;
      OE            <= 1'b0;
      DTACK         <= 1'b0;
      DTERROR       <= 1'b0;
    end else begin
      r_step_d <= STEP_IN;

      if (w_take) begin
        r_region   <= w_dec_region;
        r_uds      <= UDS_IN;
        r_lds      <= LDS_IN;
        r_wr       <= WR_IN;
        r_insig    <= w_dec_insig;
        r_lower_wr <= (ADDR_IN[23:20] == 4'h0) && WR_IN;
        r_ws_cnt   <= w_dec_ws;
      end else if (r_state == C_WAIT && r_ws_cnt != 4'd0) begin
        r_ws_cnt <= r_ws_cnt - 4'd1;
      end

      // Watchdog is frozen in STEP and ERR so a held single-step never trips.
      if (r_state == C_IDLE) begin
        r_wd_cnt <= 8'd0;
      end else if (r_state == C_WAIT || r_state == C_ACK) begin
        r_wd_cnt <= r_wd_cnt + 8'd1;
      end

      // Side effects happen once, on the edge that enters ACK.
      if (w_ack_entry) begin
        if (r_region == C_RG_IO && r_wr && !r_insig) begin
          OUTPUT_SIGNAL <= DATA[OUT_W-1:0];
        end
        if (r_lower_wr) begin
          BOOTSTRAPPED <= 1'b1;
        end
      end

      PROMCS0 <= w_promcs0_nxt;
      PROMCS1 <= w_promcs1_nxt;
      SRAMCS0 <= w_sramcs0_nxt;
      SRAMCS1 <= w_sramcs1_nxt;
      OE      <= w_oe_nxt;
      DTACK   <= w_dtack_nxt;
      DTERROR <= w_dterror_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // I/O read data: zero-extended register value on the low byte lane
  // --------------------------------------------------------------------------
  always_comb begin
    w_rd_byte = 8'h00;
    if (r_insig) begin
      w_rd_byte[IN_W-1:0] = INPUT_SIGNAL_IN;
    end else begin
      w_rd_byte[OUT_W-1:0] = OUTPUT_SIGNAL;
    end
  end

  assign w_io_drive = (r_state == C_ACK) && (r_region == C_RG_IO) && !r_wr;
  assign DATA[7:0]  = w_io_drive ? w_rd_byte : 8'hzz;

  // Only the low OUTSIG bits of the bus are ever sampled.
  assign w_unused_data = &{1'b0, DATA};

endmodule
`default_nettype wire

// File: tb/tb_bus_control_ws.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_control_ws
//  Purpose  : Self-checking bench for bus_control_ws. Directed scenarios plus
//             randomized bus cycles, checked against a transaction-level
//             model of region decode, wait latency, overlay and OUTSIG.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bus_control_ws;

  localparam int TO = 8;
  localparam int K_PROM = 0, K_SRAM = 1, K_OUT = 2, K_IN = 3, K_BAD = 4;

  logic        clk = 1'b0;
  logic        run, as_in, wr_in, uds_in, lds_in, stepen, step_in;
  logic [23:0] addr;
  logic [3:0]  insig;
  logic        tb_drv;
  logic [15:0] tb_data;
  wire  [15:0] data_bus;
  logic [3:0]  outsig;
  logic        promcs0, promcs1, sramcs0, sramcs1, oe, dtack, dterror, boot;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic        m_boot;
  logic [3:0]  m_outsig;
  logic        excl_bad = 1'b0;

  assign data_bus = tb_drv ? tb_data : 16'hzzzz;

  always #5 clk = ~clk;

  bus_control_ws #(
    .PROM_WS(2), .SRAM_WS(0), .IO_WS(1), .TIMEOUT(TO),
    .BOOT_OVERLAY(1), .OUT_W(4), .IN_W(4)
  ) dut (
    .MCLK_IN(clk), .RUN_IN(run), .AS_IN(as_in), .WR_IN(wr_in),
    .UDS_IN(uds_in), .LDS_IN(lds_in), .ADDR_IN(addr), .DATA(data_bus),
    .STEPEN_IN(stepen), .STEP_IN(step_in), .INPUT_SIGNAL_IN(insig),
    .OUTPUT_SIGNAL(outsig), .PROMCS0(promcs0), .PROMCS1(promcs1),
    .SRAMCS0(sramcs0), .SRAMCS1(sramcs1), .OE(oe), .DTACK(dtack),
    .DTERROR(dterror), .BOOTSTRAPPED(boot)
  );

  // Invariants watched on every sample point.
  always @(posedge clk) begin
    if ((dtack && dterror) || ((promcs0 | promcs1) && (sramcs0 | sramcs1)))
      excl_bad <= 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [6:0] bus_vec();
    return {promcs0, promcs1, sramcs0, sramcs1, oe, dtack, dterror};
  endfunction

  // Region rules taken directly from the address map.
  function automatic int classify(input logic [23:0] a, input logic wr, input logic lds);
    if (a[23:20] == 4'hF) return K_PROM;
    if (a[23:20] == 4'h0) return (wr || m_boot) ? K_SRAM : K_PROM;
    if (a[23:20] == 4'h1 && lds) begin
      if (a[19:0] == 20'h00001) return K_OUT;
      if (a[19:0] == 20'h00003 && !wr) return K_IN;
    end
    return K_BAD;
  endfunction

  function automatic int wait_states(input int kind);
    if (kind == K_PROM) return 2;
    if (kind == K_SRAM) return 0;
    return 1;
  endfunction

  task automatic release_bus();
    as_in = 0; uds_in = 0; lds_in = 0; wr_in = 0; tb_drv = 0; stepen = 0; step_in = 0;
  endtask

  // One complete CPU bus cycle, launched on a rising edge (DUT acts on falling).
  task automatic do_xfer(input logic [23:0] a, input logic wr, input logic uds,
                         input logic lds, input logic [15:0] wdata,
                         input logic step_mode, input int hold);
    int          kind, ws, k;
    logic [6:0]  exp_cs;
    logic        bad_seen;
    kind = classify(a, wr, lds);
    ws   = wait_states(kind);
    exp_cs = {kind == K_PROM && uds, kind == K_PROM && lds,
              kind == K_SRAM && uds, kind == K_SRAM && lds, !wr, 1'b0, 1'b0};
    @(posedge clk);
    addr = a; wr_in = wr; uds_in = uds; lds_in = lds; as_in = 1;
    tb_drv = wr; tb_data = wdata; stepen = step_mode;
    @(posedge clk);
    if (kind == K_BAD) begin
      check_eq("err_vec", 32'(bus_vec()), 32'h01);
      release_bus();
      @(posedge clk);
      check_eq("err_clear", 32'(bus_vec()), 32'h00);
    end else begin
      check_eq("cs_first", 32'(bus_vec()), 32'(exp_cs));
      if (step_mode) begin
        bad_seen = 0;
        for (int i = 0; i < hold; i++) begin
          @(posedge clk);
          if (dtack || dterror || bus_vec() != exp_cs) bad_seen = 1;
        end
        check_eq("step_hold", 32'(bad_seen), 32'h0);
        step_in = 1;
        @(posedge clk);
        step_in = 0;
        check_eq("step_ack", 32'(dtack), 32'h1);
      end else begin
        k = 1;
        while (!dtack && k < 40) begin
          @(posedge clk);
          k++;
        end
        check_eq("ack_latency", 32'(k), 32'(ws + 2));
      end
      check_eq("cs_in_ack", 32'(bus_vec()), 32'(exp_cs | 7'b0000010));
      if (!wr && (kind == K_IN || kind == K_OUT))
        check_eq("io_rdata", 32'(data_bus[7:0]),
                 32'(kind == K_IN ? {4'h0, insig} : {4'h0, m_outsig}));
      if (kind == K_OUT && wr) m_outsig = wdata[3:0];
      if (a[23:20] == 4'h0 && wr) m_boot = 1;
      check_eq("outsig", 32'(outsig), 32'(m_outsig));
      check_eq("bootstrapped", 32'(boot), 32'(m_boot));
      release_bus();
      @(posedge clk);
      check_eq("idle_vec", 32'(bus_vec()), 32'h00);
    end
  endtask

  initial begin
    int          first_ack, last_ack, first_err, sel, s;
    logic [6:0]  err_vec;
    logic [23:0] a;
    run = 0; addr = 0; insig = 0; tb_data = 0;
    release_bus();
    m_boot = 0; m_outsig = 0;
    repeat (3) @(posedge clk);
    check_eq("reset_vec", 32'(bus_vec()), 32'h00);
    check_eq("reset_out", 32'({outsig, boot}), 32'h0);
    run = 1;
    @(posedge clk);

    // Overlay: lower read from PROM, write releases it, read again from SRAM.
    do_xfer(24'h000000, 0, 1, 1, 16'h0, 0, 0);
    do_xfer(24'h000010, 1, 1, 0, 16'h1234, 0, 0);
    do_xfer(24'h000000, 0, 1, 1, 16'h0, 0, 0);
    // Signal I/O.
    do_xfer(24'h100001, 1, 0, 1, 16'h00AA, 0, 0);
    insig = 4'h5;
    do_xfer(24'h100003, 0, 0, 1, 16'h0, 0, 0);
    do_xfer(24'h100001, 0, 0, 1, 16'h0, 0, 0);
    // Invalid accesses.
    do_xfer(24'h200000, 0, 1, 1, 16'h0, 0, 0);
    do_xfer(24'h100003, 1, 0, 1, 16'h0005, 0, 0);
    do_xfer(24'h100001, 1, 1, 0, 16'h0007, 0, 0);
    // Single-step held well past the watchdog limit.
    do_xfer(24'hF00000, 0, 1, 1, 16'h0, 1, 20);

    // Watchdog: hold AS through ACK on an SRAM read.
    first_ack = 0; last_ack = 0; first_err = 0; err_vec = 0;
    @(posedge clk);
    addr = 24'h000020; wr_in = 0; uds_in = 1; lds_in = 1; as_in = 1;
    for (int k = 1; k <= TO + 3; k++) begin
      @(posedge clk);
      if (dtack) begin
        if (first_ack == 0) first_ack = k;
        last_ack = k;
      end
      if (dterror && first_err == 0) begin
        first_err = k;
        err_vec = bus_vec();
      end
    end
    check_eq("wd_first_ack", 32'(first_ack), 32'd2);
    check_eq("wd_last_ack", 32'(last_ack), 32'(TO));
    check_eq("wd_err_at", 32'(first_err), 32'(TO + 1));
    check_eq("wd_err_vec", 32'(err_vec), 32'h01);
    release_bus();
    @(posedge clk);
    check_eq("wd_clear", 32'(bus_vec()), 32'h00);

    // AS dropped during WAIT: no OUTSIG capture.
    @(posedge clk);
    addr = 24'h100001; wr_in = 1; lds_in = 1; as_in = 1; tb_drv = 1; tb_data = 16'h0003;
    @(posedge clk);
    release_bus();
    @(posedge clk);
    check_eq("abort_vec", 32'(bus_vec()), 32'h00);
    check_eq("abort_outsig", 32'(outsig), 32'(m_outsig));

    // Randomized cycles.
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0: a = {4'hF, 20'($urandom)};
        1, 6: a = {4'h0, 20'($urandom)};
        2: a = 24'h100001;
        3: a = 24'h100003;
        4: a = {4'($urandom_range(2, 14)), 20'($urandom)};
        default: a = {4'h1, 20'($urandom_range(0, 4))};
      endcase
      s = $urandom_range(1, 3);
      insig = 4'($urandom);
      do_xfer(a, 1'($urandom), 1'(s >> 1), 1'(s), 16'($urandom),
              ($urandom_range(0, 5) == 0), $urandom_range(3, 12));
    end

    // Reset in the middle of a PROM wait.
    @(posedge clk);
    addr = 24'hF00100; wr_in = 0; uds_in = 1; lds_in = 1; as_in = 1;
    @(posedge clk);
    run = 0;
    @(posedge clk);
    check_eq("midrst_vec", 32'(bus_vec()), 32'h00);
    check_eq("midrst_out", 32'({outsig, boot}), 32'h0);
    m_boot = 0; m_outsig = 0;
    release_bus();
    run = 1;
    @(posedge clk);
    do_xfer(24'h000004, 0, 0, 1, 16'h0, 0, 0);

    check_eq("exclusive_outputs", 32'(excl_bad), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
